// File: rtl/crc_pkg.sv
// Shared types and helpers for the parametrised serial CRC engine.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MSG   = 2'd1,
        SHIFT = 2'd2,
        RECV  = 2'd3
    } crc_state_e;

    // Counter must be able to hold the value W itself.
    function automatic int crc_cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// One Galois LFSR step: absorb a single serial bit into the CRC register.
module crc_lfsr_step #(
    parameter int              W    = 8,
    parameter logic [W-1:0]    TAPS = '0
) (
    input  logic [W-1:0] r,
    input  logic         d,
    output logic [W-1:0] r_next
);

    // The top bit always takes the feedback directly, so its tap bit is ignored.
    localparam logic [W-1:0] TAP_MASK = {1'b0, TAPS[W-2:0]};

    logic fb;

    always_comb begin
        fb     = d ^ r[0];
        r_next = {fb, r[W-1:1]} ^ ({W{fb}} & TAP_MASK);
    end

endmodule

// File: rtl/crc_serial_param.sv
// Serial CRC engine: absorbs a frame LSB first, then either shifts the CRC out
// (generate) or absorbs the received CRC and reports a nonzero residue (check).
module crc_serial_param
    import crc_pkg::*;
#(
    parameter int                    CRC_WIDTH = 8,
    parameter logic [CRC_WIDTH-1:0]  TAPS      = 8'h44,
    parameter logic [CRC_WIDTH-1:0]  SEED      = 8'hD8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       DATA,
    input  logic       ACTIVE,
    input  logic       MODE,
    output logic       CRC,
    output logic       Valid,
    output logic       Done,
    output logic       Err,
    output logic       Busy,
    output crc_state_e dbg_state
);

    localparam int CW = crc_cnt_width(CRC_WIDTH);
    localparam logic [CW-1:0] CNT_ONE       = CW'(1);
    localparam logic [CW-1:0] CNT_LAST_SEND = CW'(CRC_WIDTH);
    localparam logic [CW-1:0] CNT_LAST_RECV = CW'(CRC_WIDTH - 1);

    crc_state_e           state_q, state_d;
    logic [CRC_WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic                 crc_d, valid_d, done_d, err_d;
    logic [CRC_WIDTH-1:0] step_in, step_out;

    // Frame start absorbs its first bit on top of SEED, so no separate load cycle.
    assign step_in = (state_q == IDLE) ? SEED : r_q;

    crc_lfsr_step #(
        .W    (CRC_WIDTH),
        .TAPS (TAPS)
    ) u_step (
        .r      (step_in),
        .d      (DATA),
        .r_next (step_out)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            r_q     <= SEED;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            CRC     <= 1'b0;
            Valid   <= 1'b0;
            Done    <= 1'b0;
            Err     <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            CRC     <= crc_d;
            Valid   <= valid_d;
            Done    <= done_d;
            Err     <= err_d;
            Busy    <= (state_q != IDLE);
        end
    end

    // Valid has no ready: the link layer must take one CRC bit on every Valid cycle.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        crc_d   = CRC;
        valid_d = 1'b0;
        done_d  = 1'b0;
        err_d   = Err;
        unique case (state_q)
            IDLE: begin
                if (ACTIVE) begin
                    r_d     = step_out;
                    mode_d  = MODE;
                    state_d = MSG;
                end
            end
            MSG: begin
                if (ACTIVE) begin
                    r_d = step_out;
                end else if (!mode_q) begin
                    crc_d   = r_q[0];
                    valid_d = 1'b1;
                    r_d     = r_q >> 1;
                    cnt_d   = CNT_ONE;
                    state_d = SHIFT;
                end else begin
                    r_d     = step_out;
                    cnt_d   = CNT_ONE;
                    state_d = RECV;
                end
            end
            SHIFT: begin
                if (cnt_q < CNT_LAST_SEND) begin
                    crc_d   = r_q[0];
                    valid_d = 1'b1;
                    r_d     = r_q >> 1;
                    cnt_d   = cnt_q + CNT_ONE;
                end else begin
                    r_d     = SEED;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            RECV: begin
                if (cnt_q == CNT_LAST_RECV) begin
                    done_d  = 1'b1;
                    err_d   = (step_out != '0);
                    r_d     = SEED;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    r_d   = step_out;
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_crc_serial_param.sv
// Bench for crc_serial_param: two instances (SEED=0 and default SEED) share stimulus
// and are compared every cycle against a per-cycle schedule built from a frame model.
module tb_crc_serial_param;
    import crc_pkg::*;

    localparam int W = 8;
    localparam int N = 4096;

    typedef bit bitq_t[$];

    // clock / reset
    logic clk = 1'b0;
    logic rst, data, active, mode;
    always #5 clk = ~clk;

    logic crc0, valid0, done0, err0, busy0;
    logic crc1, valid1, done1, err1, busy1;
    crc_state_e st0, st1;

    crc_serial_param #(.CRC_WIDTH(8), .TAPS(8'h44), .SEED(8'h00)) u_dut0 (
        .CLK(clk), .RST(rst), .DATA(data), .ACTIVE(active), .MODE(mode),
        .CRC(crc0), .Valid(valid0), .Done(done0), .Err(err0), .Busy(busy0),
        .dbg_state(st0)
    );

    crc_serial_param #(.CRC_WIDTH(8), .TAPS(8'h44), .SEED(8'hD8)) u_dut1 (
        .CLK(clk), .RST(rst), .DATA(data), .ACTIVE(active), .MODE(mode),
        .CRC(crc1), .Valid(valid1), .Done(done1), .Err(err1), .Busy(busy1),
        .dbg_state(st1)
    );

    // scoreboard: expected outputs after each clock edge
    bit exp_valid [2][N];
    bit exp_crc   [2][N];
    bit exp_done  [2][N];
    bit exp_err   [2][N];
    bit exp_busy  [2][N];
    bit exp_rst   [N];
    bit err_hold  [2];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_on = 1'b0;

    logic [7:0] cap [2];
    logic [7:0] last_crc [2];
    logic       last_err [2];
    bit         prev_valid [2];
    int         done_cnt [2];

    function automatic logic [7:0] seed_of(input int s);
        return (s == 0) ? 8'h00 : 8'hD8;
    endfunction

    // CRC register after absorbing a bit sequence (Galois form, taps 0x44).
    function automatic logic [7:0] lfsr_run(input logic [7:0] seed, input bitq_t bits);
        logic [7:0] r;
        bit fb;
        r = seed;
        foreach (bits[i]) begin
            fb = bits[i] ^ r[0];
            r  = (r >> 1) | (fb ? 8'h80 : 8'h00);
            if (fb) r = r ^ 8'h44;
        end
        return r;
    endfunction

    function automatic bitq_t byte_bits(input logic [7:0] v);
        bitq_t q;
        for (int i = 0; i < 8; i++) q.push_back(v[i]);
        return q;
    endfunction

    task automatic cmp(input string name, input int s, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", name, s, cyc, act, exp);
        end
    endtask

    // compare process
    always @(posedge clk) begin
        logic dv, dc, dd, de, db;
        cyc = cyc + 1;
        #1;
        if (chk_on && cyc < N) begin
            for (int s = 0; s < 2; s++) begin
                dv = (s == 0) ? valid0 : valid1;
                dc = (s == 0) ? crc0   : crc1;
                dd = (s == 0) ? done0  : done1;
                de = (s == 0) ? err0   : err1;
                db = (s == 0) ? busy0  : busy1;
                if (exp_rst[cyc]) err_hold[s] = 1'b0;
                if (exp_done[s][cyc]) err_hold[s] = exp_err[s][cyc];
                cmp("valid", s, {7'b0, dv}, {7'b0, exp_valid[s][cyc]});
                cmp("done",  s, {7'b0, dd}, {7'b0, exp_done[s][cyc]});
                cmp("busy",  s, {7'b0, db}, {7'b0, exp_busy[s][cyc]});
                cmp("err",   s, {7'b0, de}, {7'b0, err_hold[s]});
                if (exp_valid[s][cyc])
                    cmp("crc_bit", s, {7'b0, dc}, {7'b0, exp_crc[s][cyc]});
                if (dv === 1'b1) cap[s] = {dc, cap[s][7:1]};
                if (prev_valid[s] && dv !== 1'b1) last_crc[s] = cap[s];
                prev_valid[s] = (dv === 1'b1);
                if (dd === 1'b1) begin
                    last_err[s] = de;
                    done_cnt[s]++;
                end
            end
        end
    end

    // driver tasks: called and returning at a falling edge
    task automatic idle(input int n);
        active = 1'b0;
        data   = 1'($urandom_range(0, 1));
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input bit md, input bitq_t msg, input bitq_t rx,
                              input bit noisy, input int abort_at);
        int k, L, rn;
        logic [7:0] v;
        bitq_t all;
        L = msg.size();
        k = cyc + 1;
        for (int s = 0; s < 2; s++) begin
            if (!md) begin
                v = lfsr_run(seed_of(s), msg);
                for (int j = 0; j < W; j++) begin
                    exp_valid[s][k+L+j] = 1'b1;
                    exp_crc[s][k+L+j]   = v[j];
                end
                for (int n = k + 1; n <= k + L + W; n++) exp_busy[s][n] = 1'b1;
            end else begin
                all = msg;
                foreach (rx[i]) all.push_back(rx[i]);
                v = lfsr_run(seed_of(s), all);
                exp_done[s][k+L+W-1] = 1'b1;
                exp_err[s][k+L+W-1]  = (v != 8'h00);
                for (int n = k + 1; n <= k + L + W - 1; n++) exp_busy[s][n] = 1'b1;
            end
        end
        for (int i = 0; i < L; i++) begin
            rst    = 1'b0;
            active = 1'b1;
            data   = msg[i];
            mode   = (i == 0) ? md : 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        for (int j = 0; j < W; j++) begin
            if (abort_at == j) begin
                rst = 1'b1;
                rn  = cyc + 1;
                exp_rst[rn] = 1'b1;
                for (int n = rn; n < N; n++)
                    for (int s = 0; s < 2; s++) begin
                        exp_valid[s][n] = 1'b0;
                        exp_done[s][n]  = 1'b0;
                        exp_busy[s][n]  = 1'b0;
                    end
                @(negedge clk);
                rst    = 1'b0;
                active = 1'b0;
                return;
            end
            active = (j == 0) ? 1'b0 : (noisy ? 1'($urandom_range(0, 1)) : 1'b0);
            data   = md ? rx[j] : 1'($urandom_range(0, 1));
            mode   = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        if (!md) begin
            active = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            data   = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        active = 1'b0;
        data   = 1'b0;
    endtask

    // stimulus
    initial begin
        bitq_t q, rx, none;
        logic [7:0] v;
        int tgt, d0;
        bit md;
        rst = 1'b1; active = 1'b0; data = 1'b0; mode = 1'b0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        q = '{1'b1};
        cmp("model_c4", 0, lfsr_run(8'h00, q), 8'hC4);
        q = '{1'b0};
        cmp("model_6c", 1, lfsr_run(8'hD8, q), 8'h6C);
        q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        cmp("model_res", 0, lfsr_run(8'h00, q), 8'h00);

        q = '{1'b1};
        send_frame(1'b0, q, none, 1'b0, -1);
        idle(2);
        cmp("gen_one", 0, last_crc[0], 8'hC4);

        q = '{1'b0};
        send_frame(1'b0, q, none, 1'b0, -1);
        idle(2);
        cmp("gen_seed", 1, last_crc[1], 8'h6C);

        q = {};
        for (int i = 0; i < 8; i++) q.push_back(1'b0);
        send_frame(1'b0, q, none, 1'b0, -1);
        idle(2);
        cmp("gen_zero", 0, last_crc[0], 8'h00);

        q  = '{1'b1};
        rx = byte_bits(8'hC4);
        d0 = done_cnt[0];
        send_frame(1'b1, q, rx, 1'b0, -1);
        idle(2);
        cmp("chk_ok_err", 0, {7'b0, last_err[0]}, 8'h00);
        cmp("chk_ok_done", 0, 8'(done_cnt[0] - d0), 8'h01);
        rx[3] = ~rx[3];
        send_frame(1'b1, q, rx, 1'b0, -1);
        idle(2);
        cmp("chk_bad_err", 0, {7'b0, last_err[0]}, 8'h01);

        send_frame(1'b0, q, none, 1'b0, 4);
        idle(2);
        send_frame(1'b0, q, none, 1'b0, -1);
        idle(2);
        cmp("gen_after_rst", 0, last_crc[0], 8'hC4);

        rx = {};
        for (int i = 0; i < 5; i++) rx.push_back(1'($urandom_range(0, 1)));
        send_frame(1'b0, rx, none, 1'b1, -1);
        send_frame(1'b0, q, none, 1'b1, -1);
        idle(2);
        cmp("gen_b2b", 0, last_crc[0], 8'hC4);

        for (int f = 0; f < 40; f++) begin
            md  = 1'($urandom_range(0, 1));
            tgt = $urandom_range(0, 1);
            q   = {};
            for (int i = 0; i < $urandom_range(1, 12); i++) q.push_back(1'($urandom_range(0, 1)));
            v  = lfsr_run(seed_of(tgt), q);
            rx = byte_bits(v);
            if ($urandom_range(0, 2) == 0) rx[$urandom_range(0, 7)] ^= 1'b1;
            send_frame(md, q, md ? rx : none, 1'($urandom_range(0, 1)), -1);
            idle($urandom_range(0, 2));
        end

        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/crc_serial_param.md
Name: crc_serial_param

Overview:
Parametrised serial CRC engine; successor to the fixed 8-bit serial CRC block. Width, tap polynomial and seed are parameters. The register is reloaded from SEED at every frame start, so no RST is needed between frames. A runtime mode selects either generate (shift the CRC out serially with Valid) or check (absorb received CRC bits and flag Err). It sits between the serial framer and the link layer, one instance per serial lane.

Parameters:
CRC_WIDTH, 8, LFSR width W (>=2)
TAPS, 8'h44, Galois tap mask; bit i set means feedback XORs into bit i (bit W-1 is always loaded with feedback)
SEED, 8'hD8, value loaded into the LFSR at frame start and on reset

Ports:
CLK  input  1  rising-edge clock
RST  input  1  synchronous, active-high reset
DATA  input  1  serial message bit, LSB first; in check mode also carries the received CRC bits after ACTIVE falls
ACTIVE  input  1  high for each message bit; frame length = number of cycles high (>=1)
MODE  input  1  0 = generate, 1 = check; sampled only on frame start
CRC  output  1  serial CRC bit, LSB first, meaningful while Valid=1
Valid  output  1  high for exactly W cycles while the CRC is shifted out (generate mode)
Done  output  1  one-cycle pulse at end of check
Err  output  1  check result, held until next Done or reset
Busy  output  1  high whenever state != IDLE

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high.
- Step function: fb = DATA ^ R[0]; R_next = {fb, R[W-1:1]} ^ ({W{fb}} & TAPS), with bit W-1 excluded from TAPS.
- RST=1 at a clock edge: state=IDLE, R=SEED, cnt=0, CRC=0, Valid=0, Done=0, Err=0, Busy=0. Overrides everything, including a frame in progress; a partial frame is discarded.
- All outputs are registered.
- IDLE: on ACTIVE=1, R <= step(SEED, DATA) (first bit absorbed that cycle), mode_q <= MODE, go to MSG.
- MSG, ACTIVE=1: R <= step(R, DATA).
- MSG, ACTIVE=0, mode_q=0: CRC <= R[0], Valid <= 1, R <= R>>1, cnt <= 1, go to SHIFT. First Valid appears at the edge that samples ACTIVE low.
- SHIFT: while cnt < W, CRC <= R[0], R <= R>>1, cnt++. After W Valid cycles, Valid <= 0, R <= SEED, go to IDLE.
- MSG, ACTIVE=0, mode_q=1: the DATA bit in this cycle is CRC bit 0; R <= step(R, DATA), cnt <= 1, go to RECV.
- RECV: R <= step(R, DATA), cnt++. On the W-th bit, Done <= 1 for one cycle, Err <= (step result != 0), R <= SEED, go to IDLE. A correct CRC leaves residue 0.
- ACTIVE and MODE are ignored in SHIFT and RECV. ACTIVE sampled high in the first IDLE cycle starts the next frame, so back-to-back frames run with one idle cycle.
- cnt width is clog2(W+1). Err is only updated on Done.

Decomposition:
- crc_pkg: state enum (IDLE, MSG, SHIFT, RECV), clog2 counter-width constant.
- Sub-module crc_lfsr_step: purely combinational next-state of R given (R, DATA, TAPS), reused by the MSG and RECV paths.

Test Plan:
- SEED=0, TAPS=8'h44, generate, ACTIVE high one cycle with DATA=1 -> Valid high 8 cycles, CRC stream 0,0,1,0,0,0,1,1 (0xC4).
- SEED=0, generate, 8 zero bits -> CRC 0x00 over 8 Valid cycles; Busy falls the cycle after Valid falls.
- Default SEED=8'hD8, generate, single DATA=0 bit -> CRC 0x6C LSB first.
- SEED=0, check, DATA=1 then bits of 0xC4 LSB first -> Done pulse, Err=0. Repeat with bit 3 flipped -> Done, Err=1.
- RST asserted mid-SHIFT (cycle 4 of Valid) -> next edge Valid=0, Busy=0, R=SEED. The next frame with DATA=1 gives 0xC4 again (SEED=0).
- Back-to-back generate frames, ACTIVE toggling during SHIFT -> toggles ignored; second frame starts from IDLE with a clean SEED reload and correct CRC.
